hsv2rgb_pipe: RTL and testbench
===============================

Name: hsv2rgb_pipe

Overview:
- Converts a hue/saturation/value pixel back to 8-bit RGB; the inverse of the vision pipeline's RGB-to-hue stage.
- Used to recolour detected-object masks and bounding overlays before the video output mux.
- 3-stage pipeline with valid/ready handshake on both sides and a global stall on backpressure.

Parameters:
- PRECISION, 16, width of hue input (integer degrees, 0..359).
- COLOR_W, 8, width of sat, val and each RGB channel; the arithmetic below is defined for 8 only.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  hue/sat/val valid this cycle
- in_ready  output  1  block accepts input this cycle
- hue  input  PRECISION  hue in degrees
- sat  input  COLOR_W  saturation, 0..255
- val  input  COLOR_W  value, 0..255
- out_valid  output  1  r/g/b valid
- out_ready  input  1  downstream accepts output
- r, g, b  output  COLOR_W each  converted colour

Behaviour:
- Reset: clk and rst as decided (rst synchronous, active-high).
  - rst clears all stage valid bits; out_valid=0 and r=g=b=0 the cycle after rst is sampled.
  - Data registers need no reset except the outputs.
  - rst mid-stream discards all in-flight pixels; no output is produced for them.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - During stall, all stage registers hold; r/g/b and out_valid stay stable.
  - Bubbles (in_valid=0 while not stalled) propagate as invalid stages.
  - Throughput is 1 pixel/cycle when out_ready=1.
- Latency: exactly 3 cycles from input transfer to out_valid when unstalled; each stall cycle adds one.
- Stage 1:
  - h' = (hue >= 360) ? 0 : hue.
  - sector = floor(h'/60), range 0..5; f = h' - 60*sector, range 0..59. Use comparisons or a constant divider, not a generic divider.
  - p = val*sat (16 bits). Register sector, f, val, p.
- Stage 2:
  - c = round(p/255), computed as (p + 128 + ((p+128)>>8)) >> 8. This is exact for p ≤ 65025.
  - m = val - c.
  - q = c*f if sector is even, else c*(60-f).
  - x = floor(q/60). Must be exact for q ≤ 15300; multiply-shift approximations must be proven exact over that range.
- Stage 3, channel select, then add m:
  - sector 0: (c, x, 0)
  - sector 1: (x, c, 0)
  - sector 2: (0, c, x)
  - sector 3: (0, x, c)
  - sector 4: (x, 0, c)
  - sector 5: (c, 0, x)
  - Register r/g/b = selected + m. Sum ≤ val ≤ 255, so no saturation logic is needed.
- Boundaries:
  - sat=0 gives r=g=b=val.
  - val=0 gives 0,0,0.
  - hue=359 stays in sector 5 with f=59.
  - in_valid asserted during stall is not accepted; the source must hold its data.

Test Plan:
- Primaries, s=255, v=255, back-to-back with out_ready=1: hue 0, 120, 240 -> (255,0,0), (0,255,0), (0,0,255) on consecutive cycles; first out_valid exactly 3 cycles after first transfer.
- Secondaries and midpoints, s=255, v=255: hue 60 -> (255,255,0); 30 -> (255,127,0); 300 -> (255,0,255); 359 -> (255,0,4).
- Greys and scaling:
  - s=0, v=200, any hue -> (200,200,200).
  - hue=0, s=128, v=200: c=100 -> (200,100,100).
  - v=0 -> (0,0,0).
  - hue=400, s=255, v=255 -> (255,0,0).
- Backpressure: stream 6 pixels with out_ready low for 4 cycles mid-stream -> in_ready low during stall; outputs held stable; no pixel dropped or duplicated; order preserved.
- Reset: assert rst for 1 cycle with 3 pixels in flight -> out_valid=0 and r=g=b=0 next cycle; none of the 3 appear. A pixel sent after reset emerges with 3-cycle latency.
- Random sweep: 10k random (hue 0..359, sat, val) against a behavioural model using the formulas above -> bit-exact match.

Source files
------------

// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: three-stage HSV to 8-bit RGB converter.
// Stage 1 folds hue into a 60-degree sector plus offset and forms val*sat.
// Stage 2 derives chroma, the intermediate component and the grey offset.
// Stage 3 routes the components onto r/g/b and adds the offset.
// A single global stall freezes every stage while the output is blocked.
module hsv2rgb_pipe #(
    parameter int PRECISION = 16,
    parameter int COLOR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] hue,
    input  logic [COLOR_W-1:0]   sat,
    input  logic [COLOR_W-1:0]   val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b
);

    localparam int PW = 2 * COLOR_W;

    // floor(q/60) as (q * 17477) >> 20. With 17477*60 = 2^20 + 44 the
    // added error is q*44/(60*2^20); for q <= 15300 that stays below 1/60,
    // so the floor never crosses an integer boundary: exact on the range.
    localparam logic [28:0] DIV60_MUL   = 29'd17477;
    localparam int          DIV60_SHIFT = 20;

    logic stall_s;

    // stage 1 state
    logic                 s1_valid_q;
    logic [2:0]           s1_sector_q, s1_sector_d;
    logic [5:0]           s1_f_q, s1_f_d;
    logic [COLOR_W-1:0]   s1_val_q;
    logic [PW-1:0]        s1_p_q, s1_p_d;

    // stage 2 state
    logic                 s2_valid_q;
    logic [2:0]           s2_sector_q;
    logic [COLOR_W-1:0]   s2_c_q, s2_c_d;
    logic [COLOR_W-1:0]   s2_x_q, s2_x_d;
    logic [COLOR_W-1:0]   s2_m_q, s2_m_d;

    // output stage state
    logic                 out_valid_q;
    logic [COLOR_W-1:0]   r_q, r_d;
    logic [COLOR_W-1:0]   g_q, g_d;
    logic [COLOR_W-1:0]   b_q, b_d;

    // stage 1/2 intermediates
    logic [PRECISION-1:0] hue_clip_s;
    logic [PRECISION-1:0] sector_base_s;
    logic [PW:0]          p_rnd_s;
    logic [PW:0]          c_sum_s;
    logic [5:0]           f_eff_s;
    logic [13:0]          q_s;
    logic [28:0]          x_prod_s;

    // Backpressure: the whole pipe freezes while the output is held.
    always_comb begin
        stall_s  = out_valid_q & ~out_ready;
        in_ready = ~stall_s;
    end

    // Stage 1: clamp hue, split into sector and offset, form val*sat.
    always_comb begin
        if (hue >= PRECISION'(360)) begin
            hue_clip_s = '0;
        end else begin
            hue_clip_s = hue;
        end

        if (hue_clip_s >= PRECISION'(300)) begin
            s1_sector_d   = 3'd5;
            sector_base_s = PRECISION'(300);
        end else if (hue_clip_s >= PRECISION'(240)) begin
            s1_sector_d   = 3'd4;
            sector_base_s = PRECISION'(240);
        end else if (hue_clip_s >= PRECISION'(180)) begin
            s1_sector_d   = 3'd3;
            sector_base_s = PRECISION'(180);
        end else if (hue_clip_s >= PRECISION'(120)) begin
            s1_sector_d   = 3'd2;
            sector_base_s = PRECISION'(120);
        end else if (hue_clip_s >= PRECISION'(60)) begin
            s1_sector_d   = 3'd1;
            sector_base_s = PRECISION'(60);
        end else begin
            s1_sector_d   = 3'd0;
            sector_base_s = '0;
        end

        s1_f_d = 6'(hue_clip_s - sector_base_s);
        s1_p_d = PW'(val) * PW'(sat);
    end

    // Stage 2: chroma = round(p/255), grey offset, and the ramp component.
    always_comb begin
        p_rnd_s = {1'b0, s1_p_q} + (PW + 1)'(128);
        c_sum_s = p_rnd_s + (p_rnd_s >> 8);
        s2_c_d  = COLOR_W'(c_sum_s >> 8);
        s2_m_d  = s1_val_q - s2_c_d;

        // odd sectors ramp down, even sectors ramp up
        if (s1_sector_q[0]) begin
            f_eff_s = 6'd60 - s1_f_q;
        end else begin
            f_eff_s = s1_f_q;
        end

        q_s      = 14'(s2_c_d) * 14'(f_eff_s);
        x_prod_s = 29'(q_s) * DIV60_MUL;
        s2_x_d   = COLOR_W'(x_prod_s >> DIV60_SHIFT);
    end

    // Stage 3: place chroma and ramp component per sector, lift by offset.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (s2_sector_q)
            3'd0: begin r_d = s2_c_q; g_d = s2_x_q; b_d = '0;     end
            3'd1: begin r_d = s2_x_q; g_d = s2_c_q; b_d = '0;     end
            3'd2: begin r_d = '0;     g_d = s2_c_q; b_d = s2_x_q; end
            3'd3: begin r_d = '0;     g_d = s2_x_q; b_d = s2_c_q; end
            3'd4: begin r_d = s2_x_q; g_d = '0;     b_d = s2_c_q; end
            3'd5: begin r_d = s2_c_q; g_d = '0;     b_d = s2_x_q; end
            default: begin r_d = '0;  g_d = '0;     b_d = '0;     end
        endcase
        r_d = r_d + s2_m_q;
        g_d = g_d + s2_m_q;
        b_d = b_d + s2_m_q;
    end

    // Stage valid bits: cleared by reset, shifted whenever the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
        end
    end

    // Stage 1/2 data registers: no reset needed, validity tracked separately.
    always_ff @(posedge clk) begin
        if (!stall_s) begin
            s1_sector_q <= s1_sector_d;
            s1_f_q      <= s1_f_d;
            s1_val_q    <= val;
            s1_p_q      <= s1_p_d;
            s2_sector_q <= s1_sector_q;
            s2_c_q      <= s2_c_d;
            s2_x_q      <= s2_x_d;
            s2_m_q      <= s2_m_d;
        end
    end

    // Output colour registers: zeroed on reset, held during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (!stall_s) begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// tb_hsv2rgb_pipe: directed and random checks of hsv2rgb_pipe against an
// arithmetic HSV->RGB reference model with an in-order expectation queue.
module tb_hsv2rgb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] hue;
    logic [7:0]  sat;
    logic [7:0]  val;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  r, g, b;

    always #5 clk = ~clk;

    hsv2rgb_pipe #(.PRECISION(16), .COLOR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hue       (hue),
        .sat       (sat),
        .val       (val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    typedef struct {
        logic [23:0] rgb;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b0;
    bit          prev_stall = 1'b0;
    bit          xfer_flag = 1'b0;
    bit          rand_ready = 1'b0;
    logic [23:0] prev_rgb = 24'd0;
    logic [23:0] pend_exp = 24'd0;
    int          st_lo = 0;
    int          st_hi = 0;

    // Reference: direct HSV->RGB arithmetic (round(p/255) via integer rounding).
    function automatic logic [23:0] model(input int h, input int s, input int v);
        int hp, sec, f, p, c, m, q, x, rr, gg, bb;
        hp  = (h >= 360) ? 0 : h;
        sec = hp / 60;
        f   = hp % 60;
        p   = v * s;
        c   = (2 * p + 255) / 510;
        m   = v - c;
        q   = (sec % 2 == 0) ? c * f : c * (60 - f);
        x   = q / 60;
        case (sec)
            0:       begin rr = c; gg = x; bb = 0; end
            1:       begin rr = x; gg = c; bb = 0; end
            2:       begin rr = 0; gg = c; bb = x; end
            3:       begin rr = 0; gg = x; bb = c; end
            4:       begin rr = x; gg = 0; bb = c; end
            default: begin rr = c; gg = 0; bb = x; end
        endcase
        return {8'(rr + m), 8'(gg + m), 8'(bb + m)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: set out_ready, sample at negedge, score, advance past posedge.
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = !((cyc + 1) >= st_lo && (cyc + 1) < st_hi);
        xfer_flag = 1'b0;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_rgb", 32'({r, g, b}), 32'(prev_rgb));
            end
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rgb", 32'({r, g, b}), 32'(e.rgb));
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{pend_exp, cyc});
                xfer_flag = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_rgb   = {r, g, b};
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and keep it until accepted (bounded).
    task automatic send(input int h, input int s, input int v, input logic [23:0] exp);
        hue      = 16'(h);
        sat      = 8'(s);
        val      = 8'(v);
        in_valid = 1'b1;
        pend_exp = exp;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (xfer_flag) break;
        end
        if (!xfer_flag) begin
            n_vec++;
            n_err++;
            $error("FAIL accept_timeout: observed=no transfer expected=transfer hue=%0d", h);
        end
    endtask

    // Stop input and wait (bounded) until every expected pixel has emerged.
    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        cycle();
    endtask

    initial begin
        int h, s, v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        hue       = 16'd0;
        sat       = 8'd0;
        val       = 8'd0;
        out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_rgb", 32'({r, g, b}), 32'd0);

        // primaries back to back, latency checked
        chk_lat = 1'b1;
        send(0,   255, 255, 24'hFF0000);
        send(120, 255, 255, 24'h00FF00);
        send(240, 255, 255, 24'h0000FF);
        drain();

        // secondaries, midpoints, greys, scaling, out-of-range hue
        send(60,    255, 255, 24'hFFFF00);
        send(30,    255, 255, {8'd255, 8'd127, 8'd0});
        send(300,   255, 255, 24'hFF00FF);
        send(359,   255, 255, {8'd255, 8'd0, 8'd4});
        send(77,    0,   200, {8'd200, 8'd200, 8'd200});
        send(0,     128, 200, {8'd200, 8'd100, 8'd100});
        send(200,   180, 0,   24'h000000);
        send(400,   255, 255, 24'hFF0000);
        send(65535, 255, 255, 24'hFF0000);
        drain();
        chk_lat = 1'b0;

        // backpressure: out_ready low 4 cycles mid-stream
        st_lo = cyc + 4;
        st_hi = st_lo + 4;
        for (int i = 0; i < 6; i++) begin
            h = $urandom_range(0, 359);
            s = $urandom_range(0, 255);
            v = $urandom_range(0, 255);
            send(h, s, v, model(h, s, v));
        end
        drain();
        st_lo = 0;
        st_hi = 0;

        // reset with three pixels in flight (output held so none transfers)
        st_lo = cyc + 1;
        st_hi = cyc + 1000;
        for (int i = 0; i < 3; i++) begin
            h = $urandom_range(0, 359);
            s = $urandom_range(1, 255);
            v = $urandom_range(1, 255);
            send(h, s, v, model(h, s, v));
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst   = 1'b0;
        st_lo = 0;
        st_hi = 0;
        exp_q.delete();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_rgb", 32'({r, g, b}), 32'd0);
        repeat (6) cycle();
        chk_lat = 1'b1;
        send(180, 255, 255, 24'h00FFFF);
        drain();
        chk_lat = 1'b0;

        // random sweep with random bubbles and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycle();
            end
            if ($urandom_range(0, 15) == 0) h = $urandom_range(0, 65535);
            else                            h = $urandom_range(0, 359);
            s = $urandom_range(0, 255);
            v = $urandom_range(0, 255);
            send(h, s, v, model(h, s, v));
        end
        rand_ready = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
